// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared types and helpers for the radix-4 Booth multiplier family.
//   state_t       : control states of the sequential multiplier
//   booth_op_t    : partial-product selection for one radix-4 digit
//   booth_recode  : maps a 3-bit overlapping multiplier group to a booth_op_t
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_ADD1 = 3'd1,
    OP_ADD2 = 3'd2,
    OP_SUB1 = 3'd3,
    OP_SUB2 = 3'd4
  } booth_op_t;

  // Group is {q[i+1], q[i], q[i-1]}; the digit value is -2*q[i+1] + q[i] + q[i-1].
  function automatic booth_op_t booth_recode(input logic [2:0] grp);
    booth_op_t op;
    case (grp)
      3'b001, 3'b010: op = OP_ADD1;
      3'b011:         op = OP_ADD2;
      3'b100:         op = OP_SUB2;
      3'b101, 3'b110: op = OP_SUB1;
      default:        op = OP_ZERO;  // 000, 111
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_radix4_recoder.sv
// -----------------------------------------------------------------------------
// booth_radix4_recoder
// Combinational radix-4 Booth digit recoder. Kept as its own block so array or
// pipelined multiplier variants can instantiate one per digit.
//   grp : {q[1], q[0], q[-1]} overlapping multiplier bits
//   op  : selected partial-product operation
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module booth_radix4_recoder
  import booth_pkg::*;
(
  input  logic [2:0] grp,
  output booth_op_t  op
);

  assign op = booth_recode(grp);

endmodule

// File: rtl/booth_radix4_multiplier.sv
// -----------------------------------------------------------------------------
// booth_radix4_multiplier
// Sequential radix-4 Booth multiplier, two multiplier bits retired per cycle.
// Signed or unsigned operation is chosen per transaction.
//   CLK100MHZ   : clock, rising edge
//   reset       : asynchronous active-low reset
//   in_valid    : operands present          in_ready  : operands can be taken
//   signed_mode : 1 = two's complement, 0 = unsigned
//   A / B       : multiplicand / multiplier (WIDTH bits)
//   out_valid   : product valid             out_ready : consumer takes product
//   P           : 2*WIDTH-bit product, held until the next product completes
//   busy        : high while an operation is in flight (RUN or DONE)
// WIDTH must be even and at least 4.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module booth_radix4_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 CLK100MHZ,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   P,
  output logic                 busy
);

  // Operands are extended by two bits so an unsigned operand is a positive
  // number to the Booth recoder and the multiplier splits into whole digits.
  localparam int ITER  = WIDTH / 2 + 1;
  localparam int EW    = WIDTH + 2;        // extended operand width
  localparam int AW    = WIDTH + 4;        // accumulator, holds +/-2M with headroom
  localparam int SW    = AW + EW + 1;      // {acc, q, q_-1}
  localparam int CNT_W = $clog2(ITER);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITER - 1);

  state_t               state;
  logic [CNT_W-1:0]     step_cnt;
  logic [EW-1:0]        m_reg;
  logic [EW-1:0]        q_reg;
  logic [AW-1:0]        acc;
  logic                 q_m1;
  logic [2*WIDTH-1:0]   p_reg;

  booth_op_t            op;
  logic [AW-1:0]        m_ext;
  logic [AW-1:0]        addend;
  logic [AW-1:0]        acc_sum;
  logic signed [SW-1:0] shift_in;
  logic [SW-1:0]        shift_out;

  function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
    return {{2{s & v[WIDTH-1]}}, v};
  endfunction

  booth_radix4_recoder u_recoder (
    .grp ({q_reg[1:0], q_m1}),
    .op  (op)
  );

  // One Booth step: add the selected multiple, then shift the whole
  // {acc, q, q_-1} chain right by two keeping the accumulator's sign.
  always_comb begin
    // NOTE: every variable gets a value before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    addend = '0;
    m_ext  = {{2{m_reg[EW-1]}}, m_reg};
    case (op)
      OP_ADD1: addend = m_ext;
      OP_ADD2: addend = m_ext << 1;
      OP_SUB1: addend = -m_ext;
      OP_SUB2: addend = -(m_ext << 1);
      default: addend = '0;
    endcase
    acc_sum   = acc + addend;
    shift_in  = {acc_sum, q_reg, q_m1};
    shift_out = shift_in >>> 2;
  end

  always_ff @(posedge CLK100MHZ or negedge reset) begin
    if (!reset) begin
      // NOTE: the datapath registers are reset along with the control state
      // because P is architecturally visible and must read zero after reset.
      state    <= IDLE;
      step_cnt <= '0;
      m_reg    <= '0;
      q_reg    <= '0;
      acc      <= '0;
      q_m1     <= 1'b0;
      p_reg    <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register here updates from
      // the values present before the edge, independent of statement order.
      case (state)
        IDLE: begin
          if (in_valid) begin
            m_reg    <= extend(A, signed_mode);
            q_reg    <= extend(B, signed_mode);
            acc      <= '0;
            q_m1     <= 1'b0;
            step_cnt <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc   <= shift_out[SW-1 -: AW];
          q_reg <= shift_out[EW:1];
          q_m1  <= shift_out[0];
          if (step_cnt == LAST_STEP) begin
            // After the last shift all multiplier bits have left q, so the
            // low 2*WIDTH bits of {acc, q} are the finished product.
            p_reg <= shift_out[2*WIDTH:1];
            state <= DONE;
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign P         = p_reg;

endmodule

// File: tb/tb_booth_radix4_multiplier.sv
// -----------------------------------------------------------------------------
// tb_booth_radix4_multiplier
// Two instances: WIDTH=8 for the directed cases and WIDTH=16 for randomized
// traffic. Drivers push expected products into per-instance queues on accept;
// independent monitors pop and compare whenever a product is presented.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_booth_radix4_multiplier;

  typedef struct {
    logic [31:0] p;
    int          acc;   // cycle in which the accept was observed
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // WIDTH = 8 instance
  logic        in_valid8 = 1'b0, s8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        in_ready8, out_valid8, busy8;
  logic [15:0] p8;

  // WIDTH = 16 instance
  logic        in_valid16 = 1'b0, s16 = 1'b0, out_ready16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, busy16;
  logic [31:0] p16;

  booth_radix4_multiplier #(.WIDTH(8)) dut8 (
    .CLK100MHZ(clk), .reset(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .signed_mode(s8),
    .A(a8), .B(b8),
    .out_valid(out_valid8), .out_ready(out_ready8), .P(p8), .busy(busy8)
  );

  booth_radix4_multiplier #(.WIDTH(16)) dut16 (
    .CLK100MHZ(clk), .reset(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16), .signed_mode(s16),
    .A(a16), .B(b16),
    .out_valid(out_valid16), .out_ready(out_ready16), .P(p16), .busy(busy16)
  );

  exp_t q8[$];
  exp_t q16[$];
  int   last_acc8 = 0;
  int   got16 = 0;
  logic seen8 = 1'b0, seen16 = 1'b0;
  logic [15:0] held8 = '0;
  logic [31:0] held16 = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: exact product of the operands read as signed or unsigned.
  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b, input logic s);
    longint x, y, p;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    p = x * y;
    return p[31:0];
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic [15:0] req);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    a8 = a; b8 = b; s8 = s; in_valid8 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready8 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("accept8", in_ready8, 1);
    e.p = {16'h0, req};
    e.acc = cyc;
    @(posedge clk); #1;
    q8.push_back(e);
    last_acc8 = e.acc;
    // Post-accept operand changes must not matter.
    in_valid8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
  endtask

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic s);
    int   n;
    exp_t e;
    a16 = a; b16 = b; s16 = s; in_valid16 = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready16 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("accept16", in_ready16, 1);
    e.p = model16(a, b, s);
    e.acc = cyc;
    @(posedge clk); #1;
    q16.push_back(e);
    in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom);
  endtask

  task automatic wait_drain8();
    int n = 0;
    @(negedge clk);
    while ((q8.size() != 0 || !in_ready8) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain8", q8.size(), 0);
  endtask

  // Monitor, WIDTH = 8
  always @(negedge clk) begin
    if (rst_n) begin
      if (q8.size() > 0) check("busy8", busy8, 1);
      if (out_valid8) begin
        if (!seen8) begin
          seen8 = 1'b1;
          held8 = p8;
          if (q8.size() == 0) check("spurious8", out_valid8, 0);
          else begin
            check("p8", p8, q8[0].p);
            check("lat8", cyc - q8[0].acc, 6);
          end
        end else begin
          check("hold8", p8, held8);
        end
        if (out_ready8) begin
          if (q8.size() > 0) q8.delete(0);
          seen8 = 1'b0;
        end
      end
    end
  end

  // Monitor, WIDTH = 16
  always @(negedge clk) begin
    if (rst_n && out_valid16) begin
      check("busy16", busy16, 1);
      if (!seen16) begin
        seen16 = 1'b1;
        held16 = p16;
        if (q16.size() == 0) check("spurious16", out_valid16, 0);
        else begin
          check("p16", p16, q16[0].p);
          check("lat16", cyc - q16[0].acc, 10);
        end
      end else begin
        check("hold16", p16, held16);
      end
      if (out_ready16) begin
        got16++;
        if (q16.size() > 0) q16.delete(0);
        seen16 = 1'b0;
      end
    end
  end

  // Random consumer backpressure for the WIDTH = 16 instance.
  initial begin
    forever begin
      @(posedge clk); #1;
      out_ready16 = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int prev, n;

    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    @(negedge clk);
    check("rst_in_ready8", in_ready8, 1);
    check("rst_out_valid8", out_valid8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_p8", p8, 16'h0000);
    check("rst_in_ready16", in_ready16, 1);
    check("rst_p16", p16, 32'h0);

    // Directed products, back to back with out_ready held high.
    issue8(8'd8, 8'd7, 1'b1, 16'h0038);
    prev = last_acc8;
    issue8(8'hF8, 8'd7, 1'b1, 16'hFFC8);
    check("throughput8", last_acc8 - prev, 7);
    issue8(8'h80, 8'h80, 1'b1, 16'h4000);
    issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
    issue8(8'hFF, 8'hFF, 1'b1, 16'h0001);
    wait_drain8();

    // Backpressure: product held for 10 cycles while a new request waits.
    out_ready8 = 1'b0;
    issue8(8'd200, 8'd3, 1'b0, 16'h0258);
    n = 0;
    @(negedge clk);
    while (!out_valid8 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("bp_valid8", out_valid8, 1);
    @(posedge clk); #1;
    a8 = 8'h7F; b8 = 8'h80; s8 = 1'b1; in_valid8 = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready8", in_ready8, 0);
      check("bp_out_valid8", out_valid8, 1);
    end
    @(posedge clk); #1;
    in_valid8 = 1'b0; out_ready8 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_ready8", in_ready8, 1);
    check("bp_idle_busy8", busy8, 0);
    check("bp_idle_valid8", out_valid8, 0);
    check("bp_retain_p8", p8, 16'h0258);
    issue8(8'h7F, 8'h80, 1'b1, 16'hC080);
    wait_drain8();

    // Reset in the middle of RUN aborts without presenting a product.
    issue8(8'd100, 8'd100, 1'b0, 16'h2710);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    q8.delete();
    #1;
    check("midrst_out_valid8", out_valid8, 0);
    check("midrst_p8", p8, 16'h0000);
    check("midrst_in_ready8", in_ready8, 1);
    check("midrst_busy8", busy8, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    issue8(8'd3, 8'hFB, 1'b1, 16'hFFF1);
    wait_drain8();

    // Randomized traffic on the wide instance.
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] ra, rb;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      ra = pick16();
      rb = pick16();
      issue16(ra, rb, 1'($urandom));
    end
    n = 0;
    @(negedge clk);
    while (q16.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drain16", q16.size(), 0);
    check("count16", got16, 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
